pconv_cn: RTL and testbench
===========================

PCONV_CN -- requirements
Module: pconv_cn

Interface
REQ-001 Parameter N, default 16, signed data and weight width.
REQ-002 Parameter INPUT_CHANNEL, default 6, input channels per pixel (1..64).
REQ-003 Parameter OUTPUT_CHANNEL, default 32, parallel output channels.
REQ-004 Parameter INPUT_SIZE, default 6, feature-map side; frame = INPUT_SIZE*INPUT_SIZE pixels.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 input_vld  in  1  pixel vector valid.
REQ-008 input_rdy  out  1  block accepts pixel; transfer when input_vld && input_rdy.
REQ-009 input_din  in  INPUT_CHANNEL*N  pixel vector; channel c at bits [(c+1)*N-1:c*N].
REQ-010 weight_din  in  OUTPUT_CHANNEL*INPUT_CHANNEL*N  weights; output o, channel c at slice o*INPUT_CHANNEL+c.
REQ-011 bias_din  in  OUTPUT_CHANNEL*32  signed per-output bias.
REQ-012 shift_din  in  OUTPUT_CHANNEL*5  per-output right-shift amount, 0..31.
REQ-013 conv_dout  out  OUTPUT_CHANNEL*N  result vector; output o at [(o+1)*N-1:o*N].
REQ-014 conv_dout_vld  out  1  result valid.
REQ-015 conv_dout_rdy  in  1  downstream accepts result.
REQ-016 conv_dout_last  out  1  qualifies final pixel of a frame, valid with conv_dout_vld.
REQ-017 conv_dout_end  out  1  level; high when no frame is in progress.

Function
REQ-018 Per output o: acc = bias[o] + sum over c of input[c]*weight[o][c], signed, full precision (ACC_W = max(32, 2N+clog2(INPUT_CHANNEL)) + 1 bits), no internal overflow.
REQ-019 Result = acc arithmetically right-shifted by shift[o] (floor), then saturated to the signed N-bit range.
REQ-020 Pipeline is exactly 3 stages: products registered, tree sum plus bias registered, shift/saturate registered; latency 3 cycles from accept to conv_dout_vld when unstalled.
REQ-021 Global stall: all stages hold when conv_dout_vld && !conv_dout_rdy; input_rdy = !(conv_dout_vld && !conv_dout_rdy).
REQ-022 Throughput one pixel per cycle with conv_dout_rdy held high; no bubbles are inserted.
REQ-023 conv_dout and conv_dout_vld remain stable while stalled.
REQ-024 Output beat counter counts transferred results 0..INPUT_SIZE^2-1 and wraps to 0 after the last beat.
REQ-025 conv_dout_last is high on the beat where counter == INPUT_SIZE^2-1.
REQ-026 conv_dout_end clears on the cycle after the first accepted pixel of a frame and sets on the cycle after the last beat transfers; a simultaneous new accept keeps it low.
REQ-027 weight_din, bias_din and shift_din are sampled combinationally at stage use; they are required stable from the first accept of a frame until its last beat transfers.

Reset
REQ-028 On rst, asynchronously: all stage valids 0, conv_dout 0, conv_dout_vld 0, conv_dout_last 0, beat counter 0, conv_dout_end 1; input_rdy 1 after release.
REQ-029 Reset mid-frame discards in-flight pixels; the next accepted pixel starts a new frame.

Configuration
REQ-030 Macro PCONV_CN_RELU_EN defined: after saturation, negative results are replaced by 0; undefined: signed saturated results pass unchanged; latency is identical either way.

Structure
REQ-031 Shared package nn_pkg holds ACC_W computation, shift width constant (5), and the N-bit saturation function.
REQ-032 One sub-module pconv_cn_unit computes a single output channel (3-stage MAC, bias, shift, saturate); pconv_cn instantiates OUTPUT_CHANNEL copies plus the shared handshake and counter logic.

Verification
REQ-033 N=16, IC=6, OC=2: input all 1, weights all 2, bias 0, shift 0 -> outputs 12 exactly 3 cycles after accept.
REQ-034 input 0x7FFF x6, weights 0x7FFF, shift 0 -> 32767; ReLU off with weights 0x8001 -> -32768; ReLU on -> 0.
REQ-035 acc=-5, shift 1 -> -3 (floor); bias 100, inputs 0, shift 2 -> 25.
REQ-036 INPUT_SIZE=2, 4 back-to-back pixels, rdy high -> 4 consecutive beats, last on beat 4, conv_dout_end high 1 cycle later.
REQ-037 conv_dout_rdy low 5 cycles mid-frame -> input_rdy low, conv_dout stable, no loss or duplication, order preserved.
REQ-038 rst asserted with 2 pixels in flight -> vld 0, end 1 immediately; the next frame's counter restarts at 0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared arithmetic helpers for the pointwise convolution datapath.
// Provides accumulator sizing, the shift-field width and N-bit signed saturation.
package nn_pkg;

    localparam int SHIFT_W = 5;
    localparam int SAT_W   = 128;

    // Accumulator width: products plus channel growth, at least the 32-bit bias, plus one bit for the bias add.
    function automatic int acc_width(input int n, input int ic);
        int base;
        base = 2 * n + $clog2(ic);
        if (base < 32) base = 32;
        return base + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_n(input logic signed [SAT_W-1:0] value,
                                                      input int n);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = 1;
        hi  = (one <<< (n - 1)) - one;
        lo  = -(one <<< (n - 1));
        if (value > hi)      return hi;
        else if (value < lo) return lo;
        else                 return value;
    endfunction

endpackage

// File: rtl/pconv_cn_unit.sv
// One output channel of the pointwise convolution: products, bias-added sum, shift and saturate.
// PCONV_CN_RELU_EN clamps negative saturated results to zero.
module pconv_cn_unit
    import nn_pkg::*;
#(
    parameter int N             = 16,
    parameter int INPUT_CHANNEL = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [INPUT_CHANNEL*N-1:0] din,
    input  logic [INPUT_CHANNEL*N-1:0] weight,
    input  logic signed [31:0]         bias,
    input  logic [SHIFT_W-1:0]         shift,
    output logic signed [N-1:0]        dout
);

    localparam int ACC_W = acc_width(N, INPUT_CHANNEL);
    localparam int PW    = 2 * N;

    logic signed [PW-1:0]    prod_q [INPUT_CHANNEL];
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] sum_q;
    logic signed [ACC_W-1:0] shifted;
    logic signed [N-1:0]     res;

    // NOTE: the product array is a handful of flops, not a RAM, so it shares the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < INPUT_CHANNEL; c++) prod_q[c] <= '0;
        end else if (en) begin
            for (int c = 0; c < INPUT_CHANNEL; c++)
                prod_q[c] <= PW'($signed(din[c*N +: N])) * PW'($signed(weight[c*N +: N]));
        end
    end

    // NOTE: combinational accumulation uses blocking '=' so each term adds to the running sum.
    always_comb begin
        sum_d = ACC_W'(bias);
        for (int c = 0; c < INPUT_CHANNEL; c++) sum_d = sum_d + ACC_W'(prod_q[c]);
    end

    always_comb begin
        shifted = sum_q >>> shift;
`ifdef PCONV_CN_RELU_EN
        res = N'(sat_n(SAT_W'(shifted), N));
        if (res[N-1]) res = '0;
`else
        res = N'(sat_n(SAT_W'(shifted), N));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            dout  <= '0;
        end else if (en) begin
            sum_q <= sum_d;
            dout  <= res;
        end
    end

endmodule

// File: rtl/pconv_cn.sv
// Pointwise (1x1) convolution: OUTPUT_CHANNEL parallel MAC units behind one stall-able 3-stage pipeline.
// Optional macro PCONV_CN_RELU_EN enables ReLU on every output channel.
module pconv_cn
    import nn_pkg::*;
#(
    parameter int N              = 16,
    parameter int INPUT_CHANNEL  = 6,
    parameter int OUTPUT_CHANNEL = 32,
    parameter int INPUT_SIZE     = 6
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      input_vld,
    output logic                                      input_rdy,
    input  logic [INPUT_CHANNEL*N-1:0]                input_din,
    input  logic [OUTPUT_CHANNEL*INPUT_CHANNEL*N-1:0] weight_din,
    input  logic [OUTPUT_CHANNEL*32-1:0]              bias_din,
    input  logic [OUTPUT_CHANNEL*SHIFT_W-1:0]         shift_din,
    output logic [OUTPUT_CHANNEL*N-1:0]               conv_dout,
    output logic                                      conv_dout_vld,
    input  logic                                      conv_dout_rdy,
    output logic                                      conv_dout_last,
    output logic                                      conv_dout_end
);

    localparam int FRAME = INPUT_SIZE * INPUT_SIZE;
    localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;

    logic             stall;
    logic             accept;
    logic             xfer;
    logic             stage1_vld;
    logic             stage2_vld;
    logic [CNT_W-1:0] beat;

    assign stall          = conv_dout_vld && !conv_dout_rdy;
    assign input_rdy      = !stall;
    assign accept         = input_vld && input_rdy;
    assign xfer           = conv_dout_vld && conv_dout_rdy;
    assign conv_dout_last = conv_dout_vld && (beat == CNT_W'(FRAME - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_vld    <= 1'b0;
            stage2_vld    <= 1'b0;
            conv_dout_vld <= 1'b0;
        end else if (!stall) begin
            stage1_vld    <= input_vld;
            stage2_vld    <= stage1_vld;
            conv_dout_vld <= stage2_vld;
        end
    end

    // The frame is over only once the last beat leaves with nothing of a following frame still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat          <= '0;
            conv_dout_end <= 1'b1;
        end else begin
            if (xfer) beat <= conv_dout_last ? '0 : beat + CNT_W'(1);
            if (accept)
                conv_dout_end <= 1'b0;
            else if (xfer && conv_dout_last && !stage1_vld && !stage2_vld)
                conv_dout_end <= 1'b1;
        end
    end

    for (genvar o = 0; o < OUTPUT_CHANNEL; o++) begin : g_unit
        pconv_cn_unit #(
            .N             (N),
            .INPUT_CHANNEL (INPUT_CHANNEL)
        ) u_unit (
            .clk    (clk),
            .rst    (rst),
            .en     (!stall),
            .din    (input_din),
            .weight (weight_din[o*INPUT_CHANNEL*N +: INPUT_CHANNEL*N]),
            .bias   (bias_din[o*32 +: 32]),
            .shift  (shift_din[o*SHIFT_W +: SHIFT_W]),
            .dout   (conv_dout[o*N +: N])
        );
    end

endmodule

// File: tb/tb_pconv_cn.sv
// Self-checking bench for pconv_cn: directed arithmetic corners plus randomized traffic vs. a scoreboard.
// Expected results follow PCONV_CN_RELU_EN when the bench is built with it.
module tb_pconv_cn;

    localparam int N     = 16;
    localparam int IC    = 6;
    localparam int OC    = 2;
    localparam int IS    = 2;
    localparam int FRAME = IS * IS;

    logic              clk = 1'b0;
    logic              rst;
    logic              input_vld;
    logic              input_rdy;
    logic [IC*N-1:0]   input_din;
    logic [OC*IC*N-1:0] weight_din;
    logic [OC*32-1:0]  bias_din;
    logic [OC*5-1:0]   shift_din;
    logic [OC*N-1:0]   conv_dout;
    logic              conv_dout_vld;
    logic              conv_dout_rdy;
    logic              conv_dout_last;
    logic              conv_dout_end;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int delivered = 0;
    logic [OC*N-1:0] sb [$];

    always #5 clk = ~clk;

    pconv_cn #(
        .N              (N),
        .INPUT_CHANNEL  (IC),
        .OUTPUT_CHANNEL (OC),
        .INPUT_SIZE     (IS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .input_vld      (input_vld),
        .input_rdy      (input_rdy),
        .input_din      (input_din),
        .weight_din     (weight_din),
        .bias_din       (bias_din),
        .shift_din      (shift_din),
        .conv_dout      (conv_dout),
        .conv_dout_vld  (conv_dout_vld),
        .conv_dout_rdy  (conv_dout_rdy),
        .conv_dout_last (conv_dout_last),
        .conv_dout_end  (conv_dout_end)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer dot product, floor division by 2^shift, clamp to N bits.
    function automatic logic [OC*N-1:0] model(input logic [IC*N-1:0] px);
        logic [OC*N-1:0] r;
        longint acc, d, q, maxv, minv;
        int sh;
        r    = '0;
        maxv = (longint'(1) << (N - 1)) - 1;
        minv = -(longint'(1) << (N - 1));
        for (int o = 0; o < OC; o++) begin
            acc = longint'($signed(bias_din[o*32 +: 32]));
            for (int c = 0; c < IC; c++)
                acc += longint'($signed(px[c*N +: N])) *
                       longint'($signed(weight_din[(o*IC+c)*N +: N]));
            sh = int'(shift_din[o*5 +: 5]);
            d  = longint'(1) << sh;
            q  = acc / d;
            if ((acc % d) != 0 && acc < 0) q = q - 1;
            if (q > maxv) q = maxv;
            if (q < minv) q = minv;
`ifdef PCONV_CN_RELU_EN
            if (q < 0) q = 0;
`endif
            r[o*N +: N] = q[N-1:0];
        end
        return r;
    endfunction

    function automatic logic [IC*N-1:0] fill(input logic [N-1:0] v);
        logic [IC*N-1:0] p;
        for (int c = 0; c < IC; c++) p[c*N +: N] = v;
        return p;
    endfunction

    task automatic set_uniform(input logic [N-1:0] w, input logic [31:0] b, input logic [4:0] sh);
        for (int o = 0; o < OC; o++) begin
            for (int c = 0; c < IC; c++) weight_din[(o*IC+c)*N +: N] = w;
            bias_din[o*32 +: 32] = b;
            shift_din[o*5 +: 5]  = sh;
        end
    endtask

    task automatic set_random();
        weight_din = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int o = 0; o < OC; o++) begin
            bias_din[o*32 +: 32] = $urandom;
            shift_din[o*5 +: 5]  = 5'($urandom_range(8, 22));
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the DUT's active edge.
    initial begin
        int beat;
        logic prev_stall;
        logic [OC*N-1:0] prev_dout;
        logic [OC*N-1:0] exp;
        beat = 0;
        prev_stall = 1'b0;
        prev_dout = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                beat = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_vld_hold", conv_dout_vld, 1'b1);
                    check("stall_dout_hold", conv_dout, prev_dout);
                end
                if (input_vld && input_rdy) begin
                    sb.push_back(model(input_din));
                    accepted++;
                end
                if (conv_dout_vld && conv_dout_rdy) begin
                    check("beat_expected", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        check("dout", conv_dout, exp);
                    end
                    check("last", conv_dout_last, beat == FRAME - 1);
                    beat = (beat + 1) % FRAME;
                    delivered++;
                end
                prev_stall = conv_dout_vld && !conv_dout_rdy;
                prev_dout  = conv_dout;
            end
        end
    end

    // One pixel into an idle pipeline; result must appear on the third edge after acceptance.
    task automatic single(input string tag, input logic [IC*N-1:0] px,
                          input logic [N-1:0] e0, input logic [N-1:0] e1);
        @(posedge clk); #1;
        input_din = px;
        input_vld = 1'b1;
        @(posedge clk); #1;
        input_vld = 1'b0;
        check({tag, "_lat1_vld"}, conv_dout_vld, 1'b0);
        check({tag, "_end_clear"}, conv_dout_end, 1'b0);
        @(posedge clk); #1;
        check({tag, "_lat2_vld"}, conv_dout_vld, 1'b0);
        @(posedge clk); #1;
        check({tag, "_lat3_vld"}, conv_dout_vld, 1'b1);
        check({tag, "_out0"}, conv_dout[N-1:0], e0);
        check({tag, "_out1"}, conv_dout[2*N-1:N], e1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check({tag, "_vld"}, conv_dout_vld, 1'b0);
        check({tag, "_end"}, conv_dout_end, 1'b1);
        check({tag, "_last"}, conv_dout_last, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        check({tag, "_rdy"}, input_rdy, 1'b1);
    endtask

    initial begin
        logic vld_seen [12];
        logic last_seen [12];
        logic end_seen [12];
        int first;
        int base;

        rst = 1'b1;
        input_vld = 1'b0;
        input_din = '0;
        weight_din = '0;
        bias_din = '0;
        shift_din = '0;
        conv_dout_rdy = 1'b1;
        #1;
        check("rst_vld", conv_dout_vld, 1'b0);
        check("rst_last", conv_dout_last, 1'b0);
        check("rst_end", conv_dout_end, 1'b1);
        check("rst_dout", conv_dout, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rdy", input_rdy, 1'b1);

        set_uniform(16'd2, 32'd0, 5'd0);
        single("ones_x2", fill(16'd1), 16'd12, 16'd12);

        set_uniform(16'h7FFF, 32'd0, 5'd0);
        single("sat_pos", fill(16'h7FFF), 16'h7FFF, 16'h7FFF);
        set_uniform(16'h8001, 32'd0, 5'd0);
`ifdef PCONV_CN_RELU_EN
        single("sat_neg", fill(16'h7FFF), 16'h0000, 16'h0000);
`else
        single("sat_neg", fill(16'h7FFF), 16'h8000, 16'h8000);
`endif

        set_uniform(16'd0, 32'd0, 5'd1);
        weight_din[0 +: N]    = 16'd1;
        weight_din[IC*N +: N] = 16'd1;
`ifdef PCONV_CN_RELU_EN
        single("floor_neg", {{(IC-1)*N{1'b0}}, 16'hFFFB}, 16'h0000, 16'h0000);
`else
        single("floor_neg", {{(IC-1)*N{1'b0}}, 16'hFFFB}, 16'hFFFD, 16'hFFFD);
`endif
        set_uniform(16'd0, 32'd100, 5'd2);
        single("bias_shift", '0, 16'd25, 16'd25);

        pulse_reset("reset_idle");

        // Back-to-back frame with the consumer always ready.
        set_random();
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            input_vld = (i < FRAME);
            input_din = {$urandom, $urandom, $urandom};
            @(negedge clk);
            vld_seen[i]  = conv_dout_vld;
            last_seen[i] = conv_dout_last;
            end_seen[i]  = conv_dout_end;
        end
        first = -1;
        for (int i = 11; i >= 0; i--) if (vld_seen[i]) first = i;
        check("b2b_first_beat", first, 3);
        if (first >= 0 && first <= 7) begin
            for (int k = 0; k < FRAME; k++) begin
                check("b2b_vld", vld_seen[first+k], 1'b1);
                check("b2b_last", last_seen[first+k], k == FRAME - 1);
            end
            check("b2b_no_extra", vld_seen[first+FRAME], 1'b0);
            check("b2b_end_low", end_seen[first+FRAME-1], 1'b0);
            check("b2b_end_set", end_seen[first+FRAME], 1'b1);
        end

        // Mid-frame stall of five cycles.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            input_vld = (i < FRAME);
            input_din = {$urandom, $urandom, $urandom};
            conv_dout_rdy = !(i >= 4 && i < 9);
            @(negedge clk);
            if (i >= 4 && i < 9) check("stall_input_rdy", input_rdy, 1'b0);
        end
        check("stall_drained", sb.size(), 0);
        check("stall_balance", delivered, accepted);

        // Randomized valid/ready traffic with fixed weights.
        set_random();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            input_vld = ($urandom_range(0, 3) != 0);
            input_din = {$urandom, $urandom, $urandom};
            conv_dout_rdy = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        input_vld = 1'b0;
        conv_dout_rdy = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rand_drained", sb.size(), 0);
        check("rand_balance", delivered, accepted);

        // Reset with two pixels in flight, then a fresh frame.
        @(posedge clk); #1;
        input_vld = 1'b1;
        input_din = {$urandom, $urandom, $urandom};
        @(posedge clk); #1;
        input_din = {$urandom, $urandom, $urandom};
        @(posedge clk); #1;
        input_vld = 1'b0;
        check("flight_end_low", conv_dout_end, 1'b0);
        pulse_reset("reset_flight");
        base = delivered;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            input_vld = (i < FRAME);
            input_din = {$urandom, $urandom, $urandom};
        end
        check("post_reset_beats", delivered - base, FRAME);
        check("post_reset_end", conv_dout_end, 1'b1);
        check("post_reset_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
